pipelined_alu: RTL
==================

PIPELINED_ALU -- requirements
Module: pipelined_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width in bits, legal range 4..32.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1: operation request present.
REQ-005 SHALL have port in_ready  output  1: block can accept a request this cycle.
REQ-006 SHALL have port ALUop  input  4: operation code.
REQ-007 SHALL have port Ci  input  1: carry-in for ADDC/SUBC.
REQ-008 SHALL have ports a, b  input  WIDTH: operands.
REQ-009 SHALL have port out_valid  output  1: result present.
REQ-010 SHALL have port out_ready  input  1: consumer accepts result.
REQ-011 SHALL have port out  output  WIDTH: result, low half for MUL.
REQ-012 SHALL have port out_hi  output  WIDTH: high half of MUL product, zero for all other ops.
REQ-013 SHALL have ports Cout, Zout, err  output  1 each: carry, zero, illegal-op flags.

Function
REQ-014 SHALL use op codes: 0 ADD, 1 ADDC, 2 SUB, 3 SUBC, 4 AND, 5 OR, 6 XOR, 7 MASK (a & ~b), 8 MUL; codes 9..15 illegal.
REQ-015 SHALL compute ADD/ADDC/SUB/SUBC in WIDTH+1 bits: {Cout,out} = a+b, a+b+Ci, a-b, a-b+Ci. SUB Cout=1 means borrow (a<b).
REQ-016 SHALL drive Cout=0 for logic ops, and SHALL set Cout = |out_hi for MUL.
REQ-017 SHALL set Zout=1 iff out (low WIDTH bits only) is all zero.
REQ-018 SHALL set err=1, out=0, out_hi=0, Cout=0, Zout=1 for illegal op codes; the result is still delivered through the handshake.
REQ-019 SHALL use a three-state FSM: IDLE, BUSY, DONE.
REQ-020 SHALL drive in_ready=1 only in IDLE; accept occurs on a clock edge with in_valid && in_ready; operands and op are registered at accept.
REQ-021 SHALL go IDLE->DONE on accepting a non-MUL op; the registered result is visible with out_valid=1 in the next cycle (latency 1).
REQ-022 SHALL go IDLE->BUSY on accepting MUL, then run an unsigned shift-add multiply, one partial product per cycle, for exactly WIDTH cycles, then go BUSY->DONE; out_valid rises WIDTH+1 cycles after the accept edge.
REQ-023 SHALL hold out_valid=1 in DONE, with out/out_hi/Cout/Zout/err stable, until an edge with out_ready=1; it SHALL then return to IDLE.
REQ-024 SHALL NOT accept a new request in BUSY or DONE; in_valid there SHALL be ignored with no side effect.
REQ-025 SHALL keep outputs unchanged while in_valid is low in IDLE; only out_valid=0 is meaningful there.

Reset
REQ-026 SHALL, while rst_n=0, immediately force state=IDLE, in_ready=1, out_valid=0, and out, out_hi, Cout, Zout, err to 0, independent of clk.
REQ-027 SHALL abandon any in-flight MUL or undelivered result when reset is asserted, and produce no result for it after reset is released.
REQ-028 SHALL accept a request on the first rising edge after rst_n goes high.

Configuration
REQ-029 SHALL compile the MUL datapath (partial-product register, iteration counter, BUSY state) only when macro ALU_MUL_EN is defined.
REQ-030 SHALL, without ALU_MUL_EN, treat op 8 as illegal per REQ-018 with 1-cycle latency, and SHALL never enter BUSY.

Verification
REQ-031 SHALL cover: WIDTH=8, ADD a=0xF0 b=0x20 -> one cycle later out=0x10, Cout=1, Zout=0, err=0.
REQ-032 SHALL cover: SUB a=0x05 b=0x05 -> out=0x00, Zout=1, Cout=0; SUB a=0x03 b=0x05 -> out=0xFE, Cout=1; SUBC a=0x03 b=0x05 Ci=1 -> out=0xFF, Cout=1.
REQ-033 SHALL cover: ALU_MUL_EN defined, MUL a=0xFF b=0xFF -> out_valid exactly 9 cycles after accept, out=0x01, out_hi=0xFE, Cout=1; in_ready=0 throughout.
REQ-034 SHALL cover: backpressure, XOR a=0xAA b=0xAA with out_ready=0 for 3 cycles -> out_valid, out=0x00, Zout=1 held stable; return to IDLE on the edge with out_ready=1.
REQ-035 SHALL cover: rst_n pulsed low mid-MUL (cycle 4) -> all outputs 0 asynchronously, in_ready=1, no stale result afterwards.
REQ-036 SHALL cover: op 0xA -> err=1, out=0, Zout=1; without ALU_MUL_EN, op 8 -> err=1 after 1 cycle.

Source files
------------

// File: rtl/pipelined_alu_if.sv
// pipelined_alu_if: request/result handshake bundle for pipelined_alu
interface pipelined_alu_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALUop;
    logic             Ci;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_hi;
    logic             Cout;
    logic             Zout;
    logic             err;

    modport master (
        output in_valid, ALUop, Ci, a, b, out_ready,
        input  in_ready, out_valid, out, out_hi, Cout, Zout, err
    );

    modport slave (
        input  in_valid, ALUop, Ci, a, b, out_ready,
        output in_ready, out_valid, out, out_hi, Cout, Zout, err
    );
endinterface

// File: rtl/pipelined_alu.sv
// pipelined_alu: handshaked ALU with optional multi-cycle shift-add MUL (enabled by macro ALU_MUL_EN)
module pipelined_alu #(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst_n,
    pipelined_alu_if.slave  bus
);
`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int CW = $clog2(WIDTH + 1);
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]     psum;
    logic               is_mul;
`else
    typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif
    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d, hi_q, hi_d;
    logic             cout_q, cout_d, zout_q, zout_d, err_q, err_d;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c, alu_e;

    // Single-cycle result for every op except MUL; unknown codes flag err with a zero result
    always_comb begin
        alu_r = '0;
        alu_c = 1'b0;
        alu_e = 1'b0;
        case (bus.ALUop)
            4'd0: {alu_c, alu_r} = {1'b0, bus.a} + {1'b0, bus.b};
            4'd1: {alu_c, alu_r} = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.Ci};
            4'd2: {alu_c, alu_r} = {1'b0, bus.a} - {1'b0, bus.b};
            4'd3: {alu_c, alu_r} = {1'b0, bus.a} - {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.Ci};
            4'd4: alu_r = bus.a & bus.b;
            4'd5: alu_r = bus.a | bus.b;
            4'd6: alu_r = bus.a ^ bus.b;
            4'd7: alu_r = bus.a & ~bus.b;
            default: alu_e = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    assign is_mul = bus.ALUop == 4'd8;
    assign psum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
`endif

    // Next-state and result capture; outputs only move at accept or MUL completion
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        hi_d    = hi_q;
        cout_d  = cout_q;
        zout_d  = zout_q;
        err_d   = err_q;
`ifdef ALU_MUL_EN
        prod_d  = prod_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
`ifdef ALU_MUL_EN
                    if (is_mul) begin
                        state_d = BUSY;
                        prod_d  = {{WIDTH{1'b0}}, bus.b};
                        mcand_d = bus.a;
                        cnt_d   = '0;
                    end else begin
`else
                    begin
`endif
                        state_d = DONE;
                        out_d   = alu_r;
                        hi_d    = '0;
                        cout_d  = alu_c;
                        zout_d  = alu_r == '0;
                        err_d   = alu_e;
                    end
                end
            end
`ifdef ALU_MUL_EN
            BUSY: begin
                if (cnt_q == CW'(WIDTH)) begin
                    state_d = DONE;
                    out_d   = prod_q[WIDTH-1:0];
                    hi_d    = prod_q[2*WIDTH-1:WIDTH];
                    cout_d  = |prod_q[2*WIDTH-1:WIDTH];
                    zout_d  = prod_q[WIDTH-1:0] == '0;
                    err_d   = 1'b0;
                end else begin
                    prod_d = {psum, prod_q[WIDTH-1:1]};
                    cnt_d  = cnt_q + 1'b1;
                end
            end
`endif
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset drops any in-flight or undelivered work
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            hi_q    <= '0;
            cout_q  <= 1'b0;
            zout_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef ALU_MUL_EN
            prod_q  <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            hi_q    <= hi_d;
            cout_q  <= cout_d;
            zout_q  <= zout_d;
            err_q   <= err_d;
`ifdef ALU_MUL_EN
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.out       = out_q;
    assign bus.out_hi    = hi_q;
    assign bus.Cout      = cout_q;
    assign bus.Zout      = zout_q;
    assign bus.err       = err_q;
endmodule
